cxapbasyncbridge_cdc_launch: RTL and testbench

- Source-domain launch stage of the APB async bridge.
- Captures one payload word and holds it stable on `data_async`, then runs a 4-phase req/ack handshake with the destination domain.
- Downstream, the destination synchronises `req_async` and uses it as the `valid` of the clamp-AND stage that gates `data_async`.
- Guarantees `data_async` never changes while `req_async` is high or an acknowledge is pending.

---
 rtl/cxapbasyncbridge_cdc_launch.sv | 106 ++++++++++
 tb/tb_cxapbasyncbridge_cdc_launch.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cxapbasyncbridge_cdc_launch.sv
// Source-domain launch stage of the APB async bridge: holds one payload on data_async
// and runs a 4-phase req/ack handshake. Define CXAPB_CDC_LAUNCH_CHECK_EN for simulation-only protocol checks.
module cxapbasyncbridge_cdc_launch #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             req_async,
    output logic [WIDTH-1:0] data_async,
    input  logic             ack_async,
    output logic             busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_ACKWAIT = 2'd2;

    logic [1:0]             state_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic                   ack_sync;
    logic                   accept;

    // Plain flop chain: nothing may sit between the stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], ack_async};
        end
    end

    assign ack_sync = ack_sync_q[SYNC_STAGES-1];

    // A late or spurious ack still high in IDLE blocks the next launch.
    assign src_ready = ~reset & (state_q == ST_IDLE) & ~ack_sync;
    assign accept    = src_valid & src_ready;
    assign busy      = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_async  <= 1'b0;
            data_async <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_async <= src_data;
                        req_async  <= 1'b1;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_sync) begin
                        req_async <= 1'b0;
                        state_q   <= ST_ACKWAIT;
                    end
                end
                ST_ACKWAIT: begin
                    if (!ack_sync) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    req_async <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CXAPB_CDC_LAUNCH_CHECK_EN
    logic [WIDTH-1:0] chk_data_q;
    logic             chk_busy_q;
    logic             chk_ack_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chk_data_q <= '0;
            chk_busy_q <= 1'b0;
            chk_ack_q  <= 1'b0;
        end else begin
            if (busy && chk_busy_q && (data_async !== chk_data_q)) begin
                $display("FATAL : CDC launch data unstable");
                $stop;
            end
            if (ack_sync && !chk_ack_q && (state_q == ST_IDLE)) begin
                $display("FATAL : CDC ack protocol violation");
                $stop;
            end
            if (accept && $isunknown(src_data)) begin
                $display("FATAL : CDC launch src_data X/Z on accept");
                $stop;
            end
            chk_data_q <= data_async;
            chk_busy_q <= busy;
            chk_ack_q  <= ack_sync;
        end
    end
`endif

endmodule

// File: tb/tb_cxapbasyncbridge_cdc_launch.sv
// Directed bench for cxapbasyncbridge_cdc_launch: instance 0 has SYNC_STAGES=2, instance 1 SYNC_STAGES=4.
module tb_cxapbasyncbridge_cdc_launch;

    logic        clk;
    logic        reset;
    logic        valid [2];
    logic [31:0] data  [2];
    logic        ack   [2];
    logic        ready [2];
    logic        req   [2];
    logic [31:0] dout  [2];
    logic        busy  [2];

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;
    logic [31:0] sb[$];
    logic [31:0] exp_d;

    cxapbasyncbridge_cdc_launch #(.WIDTH(32), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .src_valid(valid[0]), .src_data(data[0]),
        .src_ready(ready[0]), .req_async(req[0]), .data_async(dout[0]),
        .ack_async(ack[0]), .busy(busy[0]));

    cxapbasyncbridge_cdc_launch #(.WIDTH(32), .SYNC_STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .src_valid(valid[1]), .src_data(data[1]),
        .src_ready(ready[1]), .req_async(req[1]), .data_async(dout[1]),
        .ack_async(ack[1]), .busy(busy[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transfer with exact latency checks; data_async checked every cycle while busy.
    task automatic do_xfer(input int sel, input logic [31:0] d, input int unsigned delay);
        int unsigned s;
        s = (sel == 1) ? 4 : 2;
        chk("pre_ready", {31'd0, ready[sel]}, 32'd1);
        valid[sel] = 1'b1;
        data[sel]  = d;
        sb.push_back(d);
        tick();
        chk("accept_req", {31'd0, req[sel]}, 32'd1);
        exp_d = sb.pop_front();
        chk("accept_data", dout[sel], exp_d);
        valid[sel] = 1'b0;
        data[sel]  = $urandom;
        for (int unsigned i = 0; i < delay; i++) begin
            tick();
            chk("req_hold", {31'd0, req[sel]}, 32'd1);
            chk("data_hold_req", dout[sel], exp_d);
        end
        ack[sel] = 1'b1;
        for (int unsigned i = 0; i < s; i++) begin
            tick();
            chk("req_before_fall", {31'd0, req[sel]}, 32'd1);
            chk("data_hold_sync", dout[sel], exp_d);
        end
        tick();
        chk("req_fall", {31'd0, req[sel]}, 32'd0);
        chk("busy_ackwait", {31'd0, busy[sel]}, 32'd1);
        chk("data_hold_ackwait", dout[sel], exp_d);
        ack[sel] = 1'b0;
        for (int unsigned i = 0; i < s; i++) begin
            tick();
            chk("ready_low_ackwait", {31'd0, ready[sel]}, 32'd0);
            chk("data_hold_release", dout[sel], exp_d);
        end
        tick();
        chk("ready_back", {31'd0, ready[sel]}, 32'd1);
        chk("busy_idle", {31'd0, busy[sel]}, 32'd0);
        chk("data_kept_idle", dout[sel], exp_d);
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            data[i]  = '0;
            ack[i]   = 1'b0;
        end

        // Reset asserted mid-cycle with src_valid high.
        #2;
        reset    = 1'b1;
        valid[0] = 1'b1;
        data[0]  = 32'h1234_5678;
        #1;
        chk("rst_req", {31'd0, req[0]}, 32'd0);
        chk("rst_data", dout[0], 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        chk("rst_ready", {31'd0, ready[0]}, 32'd0);
        chk("rst_req4", {31'd0, req[1]}, 32'd0);
        tick();
        tick();
        chk("rst_hold_req", {31'd0, req[0]}, 32'd0);
        valid[0] = 1'b0;
        reset    = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, ready[0]}, 32'd1);
        chk("post_rst_req", {31'd0, req[0]}, 32'd0);

        // Single transfer.
        do_xfer(0, 32'hA5A5_0001, 0);

        // Back-to-back with src_valid held high.
        valid[0] = 1'b1;
        data[0]  = 32'h1;
        sb.push_back(32'h1);
        tick();
        chk("b2b_req1", {31'd0, req[0]}, 32'd1);
        exp_d = sb.pop_front();
        chk("b2b_data1", dout[0], exp_d);
        data[0] = 32'h2;
        sb.push_back(32'h2);
        tick();
        chk("b2b_data1_hold", dout[0], 32'h1);
        ack[0] = 1'b1;
        tick();
        tick();
        chk("b2b_req_hi", {31'd0, req[0]}, 32'd1);
        tick();
        chk("b2b_req_fall", {31'd0, req[0]}, 32'd0);
        chk("b2b_data1_ackwait", dout[0], 32'h1);
        ack[0] = 1'b0;
        tick();
        tick();
        chk("b2b_still_ackwait", {31'd0, busy[0]}, 32'd1);
        chk("b2b_data1_late", dout[0], 32'h1);
        tick();
        chk("b2b_idle_reentry", {31'd0, busy[0]}, 32'd0);
        chk("b2b_no_accept_yet", {31'd0, req[0]}, 32'd0);
        chk("b2b_ready_reentry", {31'd0, ready[0]}, 32'd1);
        chk("b2b_data1_idle", dout[0], 32'h1);
        tick();
        chk("b2b_req2", {31'd0, req[0]}, 32'd1);
        exp_d = sb.pop_front();
        chk("b2b_data2", dout[0], exp_d);
        valid[0] = 1'b0;
        ack[0]   = 1'b1;
        repeat (3) tick();
        chk("b2b_req2_fall", {31'd0, req[0]}, 32'd0);
        ack[0] = 1'b0;
        repeat (3) tick();
        chk("b2b_done_ready", {31'd0, ready[0]}, 32'd1);

        // Spurious ack while IDLE.
        ack[0] = 1'b1;
        tick();
        tick();
        chk("spur_ready_low", {31'd0, ready[0]}, 32'd0);
        valid[0] = 1'b1;
        data[0]  = 32'h3;
        sb.push_back(32'h3);
        tick();
        tick();
        chk("spur_no_req", {31'd0, req[0]}, 32'd0);
        chk("spur_no_busy", {31'd0, busy[0]}, 32'd0);
        chk("spur_no_capture", dout[0], 32'h2);
        ack[0] = 1'b0;
        tick();
        tick();
        chk("spur_not_yet", {31'd0, req[0]}, 32'd0);
        tick();
        chk("spur_capture_req", {31'd0, req[0]}, 32'd1);
        exp_d = sb.pop_front();
        chk("spur_capture_data", dout[0], exp_d);
        valid[0] = 1'b0;
        ack[0]   = 1'b1;
        repeat (3) tick();
        ack[0] = 1'b0;
        repeat (3) tick();
        chk("spur_done_ready", {31'd0, ready[0]}, 32'd1);

        // Reset during REQ, ack never returned.
        valid[0] = 1'b1;
        data[0]  = 32'h4;
        tick();
        chk("rreq_req", {31'd0, req[0]}, 32'd1);
        valid[0] = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        chk("rreq_req_drop", {31'd0, req[0]}, 32'd0);
        chk("rreq_busy", {31'd0, busy[0]}, 32'd0);
        chk("rreq_data", dout[0], 32'd0);
        chk("rreq_ready", {31'd0, ready[0]}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("rreq_ready_after", {31'd0, ready[0]}, 32'd1);
        do_xfer(0, 32'hDEAD_BEEF, 2);

        // SYNC_STAGES=4 with randomised ack delays.
        do_xfer(1, 32'hC0FF_EE04, 0);
        for (int k = 0; k < 8; k++) begin
            do_xfer(1, $urandom, $urandom_range(0, 20));
        end
        for (int k = 0; k < 4; k++) begin
            do_xfer(0, $urandom, $urandom_range(0, 20));
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
